sbp_lookup_ingress: RTL and testbench
=====================================

// Module: sbp_lookup_ingress
// PURPOSE
//  Head of the SBP lookup pipeline, directly upstream of stage 1.
//  - Accepts IP lookup requests and table-update commands over valid/ready.
//  - Arbitrates between them and emits exactly one slot per clock: lookup, update or bubble.
//  - Stages downstream have no backpressure; this block is the only flow-control point.
//  - Bubble encoding: stage_id_o=0, so no stage selects it.
// PARAMETERS
//  STAGE_ID_BITS   6   width of stage_id fields
//  LOCATION_BITS   11  width of location fields
//  RESULT_BITS     24  width of result field (nibble-padded stage/location/child_lr)
//  FIRST_STAGE_ID  1   stage_id given to every injected lookup
//  FIFO_DEPTH      4   lookup request FIFO entries; power of 2, >=2
//  MAX_UPD_BURST   8   max consecutive update slots while lookups wait, >=1
// PORTS
//  clk               in   1    clock
//  rst               in   1    reset, asynchronous, active-low
//  lk_valid_i        in   1    lookup request valid
//  lk_ready_o        out  1    lookup request ready
//  lk_ip_addr_i      in   32   address to look up
//  upd_valid_i       in   1    update command valid
//  upd_ready_o       out  1    update command ready
//  upd_prefix_i      in   32   prefix to write
//  upd_prefix_len_i  in   6    prefix length
//  upd_stage_id_i    in   STAGE_ID_BITS  target stage
//  upd_location_i    in   LOCATION_BITS  target location
//  upd_result_i      in   RESULT_BITS    node payload to write
//  update_o          out  1    slot is an update
//  ip_addr_o         out  32   ip address, or prefix for updates
//  bit_pos_o         out  6    0 for lookups; prefix length for updates
//  stage_id_o        out  STAGE_ID_BITS
//  location_o        out  LOCATION_BITS
//  result_o          out  RESULT_BITS
// BEHAVIOUR
//  Reset
//   - All outputs 0; lk_ready_o=1, upd_ready_o=1 once released.
//   - Assertion mid-operation empties the FIFO, drops any pending update and clears burst_cnt.
//  Accept
//   - Lookup: transfer when lk_valid_i&&lk_ready_o; pushed to the FIFO.
//   - lk_ready_o = !fifo_full || pop_this_cycle, so push and pop can occur together when full.
//   - Update: transfer when upd_valid_i&&upd_ready_o; captured into a 1-entry pending register.
//   - upd_ready_o = !upd_pend || emit_upd_this_cycle.
//   - upd_prefix_len_i>32 is saturated to 32 at capture.
//   - upd_stage_id_i==0 is accepted and discarded; it never sets upd_pend.
//  Arbitration (combinational, once per cycle; result registered into the outputs)
//   - Rule 1: upd_pend && (burst_cnt<MAX_UPD_BURST || fifo_empty) -> update slot.
//     burst_cnt+1, saturating at MAX_UPD_BURST.
//   - Rule 2: else if !fifo_empty -> lookup slot, pop, burst_cnt=0.
//   - Rule 3: else bubble, burst_cnt=0.
//  Slot contents
//   - lookup: update_o=0, ip_addr=fifo head, bit_pos=0, stage_id=FIRST_STAGE_ID,
//     location=0, result=0.
//   - update: update_o=1, ip_addr=prefix, bit_pos=len, stage_id, location and result
//     taken from the pending register.
//   - bubble: all outputs 0.
//  Latency
//   - Lookup accepted at edge N into an empty FIFO with no pending update -> on outputs after edge N+2.
//   - Update accepted at edge N -> on outputs after edge N+1, or later if arbitration defers it.
//  Ordering
//   - Lookups leave in acceptance order.
//   - Updates leave in acceptance order; only one can be pending at a time.
// CONFIGURATION
//  SBP_INGRESS_STATS_EN defined
//   - Adds ports cnt_lookup_o[31:0] and cnt_update_o[31:0].
//   - Each counts emitted slots of its kind; saturates at 2^32-1; reset 0.
//  Undefined
//   - Ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  - Package sbp_pkg: BIT_POS_BITS=6, pad/width localparams, RESULT_BITS derivation.
//  - sbp_pkg also holds typedef sbp_slot_t (update, ip_addr, bit_pos, stage_id, location, result)
//    and typedef sbp_upd_cmd_t.
//  - Sub-module sbp_ingress_fifo: synchronous FIFO with full/empty, same-cycle push+pop when full.
//  - The arbiter and output register live in this module.
// TESTING
//  1. Reset, then a single lookup 0xC0A80101 -> outputs after edge N+2:
//     update_o=0, ip=C0A80101, bit_pos=0, stage_id=1, location=0, result=0; bubbles after that.
//  2. Update prefix 0x0A000000, len 8, stage 3, loc 5, result 0x031050 -> one slot:
//     update_o=1, bit_pos=8, stage_id=3, location=5.
//  3. Update every cycle with 6 lookups queued, MAX_UPD_BURST=8 -> output pattern
//     8 updates, 1 lookup, repeating until the FIFO drains.
//  4. lk_valid_i held high and no updates, FIFO_DEPTH=4 -> lk_ready_o never drops after the
//     pipeline fills; one lookup per cycle, in order.
//  5. Edge cases: len=40 emits bit_pos=32; stage_id=0 is accepted (ready=1) and no update slot appears.
//  6. Reset asserted with 3 lookups queued and an update pending -> after release: outputs 0,
//     no stale slot emitted, both readys 1.

Source files
------------

// File: rtl/sbp_pkg.sv
// Shared types and widths for the SBP lookup pipeline.
// The result payload is the stage id, location and child_lr flag, each padded
// to a whole number of nibbles.
package sbp_pkg;

    localparam int IP_BITS        = 32;
    localparam int BIT_POS_BITS   = 6;
    localparam int STAGE_ID_BITS  = 6;
    localparam int LOCATION_BITS  = 11;
    localparam int CHILD_LR_BITS  = 1;
    localparam int MAX_PREFIX_LEN = 32;

    // Round a field width up to whole nibbles.
    function automatic int nibble_pad(input int width);
        return ((width + 3) / 4) * 4;
    endfunction

    localparam int RESULT_BITS = nibble_pad(STAGE_ID_BITS) +
                                 nibble_pad(LOCATION_BITS) +
                                 nibble_pad(CHILD_LR_BITS);

    // One pipeline slot as seen by stage 1.
    typedef struct packed {
        logic                     update;
        logic [IP_BITS-1:0]       ip_addr;
        logic [BIT_POS_BITS-1:0]  bit_pos;
        logic [STAGE_ID_BITS-1:0] stage_id;
        logic [LOCATION_BITS-1:0] location;
        logic [RESULT_BITS-1:0]   result;
    } sbp_slot_t;

    // A captured table-update command.
    typedef struct packed {
        logic [IP_BITS-1:0]       prefix;
        logic [BIT_POS_BITS-1:0]  prefix_len;
        logic [STAGE_ID_BITS-1:0] stage_id;
        logic [LOCATION_BITS-1:0] location;
        logic [RESULT_BITS-1:0]   result;
    } sbp_upd_cmd_t;

    // Prefix lengths beyond a full IPv4 address are clamped to 32.
    function automatic logic [BIT_POS_BITS-1:0] sat_prefix_len(input logic [BIT_POS_BITS-1:0] len);
        return (len > BIT_POS_BITS'(MAX_PREFIX_LEN)) ? BIT_POS_BITS'(MAX_PREFIX_LEN) : len;
    endfunction

endpackage

// File: rtl/sbp_ingress_fifo.sv
// Lookup request FIFO for the SBP ingress block.
// A word written at one edge becomes readable one edge later: the read side
// tracks a delayed copy of the write pointer. Full counts every stored word,
// so push and pop may happen together while full.
module sbp_ingress_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int PTR_BITS = $clog2(DEPTH);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [PTR_BITS:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS:0] vis_ptr_q, vis_ptr_d;
    logic [PTR_BITS:0] rd_ptr_q, rd_ptr_d;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (wr_ptr_q - rd_ptr_q) == (PTR_BITS + 1)'(DEPTH);
    assign empty_o = (vis_ptr_q == rd_ptr_q);
    assign head_o  = mem_q[rd_ptr_q[PTR_BITS-1:0]];

    // Next-state pointers; a pop frees room for a same-cycle push.
    always_comb begin
        // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
        do_pop    = pop_i && !empty_o;
        do_push   = push_i && (!full_o || do_pop);
        wr_ptr_d  = wr_ptr_q + {{PTR_BITS{1'b0}}, do_push};
        rd_ptr_d  = rd_ptr_q + {{PTR_BITS{1'b0}}, do_pop};
        vis_ptr_d = wr_ptr_q;
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        if (!rst) begin
            wr_ptr_q  <= '0;
            vis_ptr_q <= '0;
            rd_ptr_q  <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            vis_ptr_q <= vis_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is not reset; pointers alone decide which words are valid.
        if (do_push) begin
            mem_q[wr_ptr_q[PTR_BITS-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/sbp_lookup_ingress.sv
// Head of the SBP lookup pipeline: accepts lookups and table updates,
// arbitrates, and registers exactly one slot per clock (lookup, update or
// bubble with stage_id 0). Updates win unless MAX_UPD_BURST of them have run
// back to back while lookups wait.
// Optional: define SBP_INGRESS_STATS_EN to add saturating slot counters
// cnt_lookup_o / cnt_update_o.
module sbp_lookup_ingress
    import sbp_pkg::*;
#(
    parameter int FIRST_STAGE_ID = 1,
    parameter int FIFO_DEPTH     = 4,
    parameter int MAX_UPD_BURST  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     lk_valid_i,
    output logic                     lk_ready_o,
    input  logic [31:0]              lk_ip_addr_i,
    input  logic                     upd_valid_i,
    output logic                     upd_ready_o,
    input  logic [31:0]              upd_prefix_i,
    input  logic [5:0]               upd_prefix_len_i,
    input  logic [STAGE_ID_BITS-1:0] upd_stage_id_i,
    input  logic [LOCATION_BITS-1:0] upd_location_i,
    input  logic [RESULT_BITS-1:0]   upd_result_i,
    output logic                     update_o,
    output logic [31:0]              ip_addr_o,
    output logic [5:0]               bit_pos_o,
    output logic [STAGE_ID_BITS-1:0] stage_id_o,
    output logic [LOCATION_BITS-1:0] location_o,
`ifdef SBP_INGRESS_STATS_EN
    output logic [31:0]              cnt_lookup_o,
    output logic [31:0]              cnt_update_o,
`endif
    output logic [RESULT_BITS-1:0]   result_o
);

    localparam int BURST_BITS = $clog2(MAX_UPD_BURST + 1);

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [IP_BITS-1:0]    fifo_head;
    logic                  lk_push;
    logic                  sel_upd;
    logic                  sel_lk;
    logic                  upd_take;

    logic                  upd_pend_q, upd_pend_d;
    sbp_upd_cmd_t          upd_cmd_q, upd_cmd_d;
    logic [BURST_BITS-1:0] burst_cnt_q, burst_cnt_d;
    sbp_slot_t             slot_q, slot_d;

    sbp_ingress_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (IP_BITS)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (lk_push),
        .push_data_i (lk_ip_addr_i),
        .pop_i       (sel_lk),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (fifo_head)
    );

    // Slot arbitration: pending update first unless its burst is spent and lookups wait.
    always_comb begin
        sel_upd = upd_pend_q &&
                  ((burst_cnt_q < BURST_BITS'(MAX_UPD_BURST)) || fifo_empty);
        sel_lk  = !sel_upd && !fifo_empty;
    end

    assign lk_ready_o  = !fifo_full || sel_lk;
    assign lk_push     = lk_valid_i && lk_ready_o;
    assign upd_ready_o = !upd_pend_q || sel_upd;
    assign upd_take    = upd_valid_i && upd_ready_o;

    // Build the next slot, the burst count and the pending-update register.
    always_comb begin
        slot_d      = '0;
        burst_cnt_d = '0;
        upd_pend_d  = upd_pend_q;
        upd_cmd_d   = upd_cmd_q;

        if (sel_upd) begin
            slot_d.update   = 1'b1;
            slot_d.ip_addr  = upd_cmd_q.prefix;
            slot_d.bit_pos  = upd_cmd_q.prefix_len;
            slot_d.stage_id = upd_cmd_q.stage_id;
            slot_d.location = upd_cmd_q.location;
            slot_d.result   = upd_cmd_q.result;
            burst_cnt_d     = (burst_cnt_q == BURST_BITS'(MAX_UPD_BURST)) ?
                              burst_cnt_q : burst_cnt_q + BURST_BITS'(1);
            upd_pend_d      = 1'b0;
        end else if (sel_lk) begin
            slot_d.ip_addr  = fifo_head;
            slot_d.stage_id = STAGE_ID_BITS'(FIRST_STAGE_ID);
        end

        // Stage id 0 addresses no stage, so such a command is consumed and dropped.
        if (upd_take && (upd_stage_id_i != '0)) begin
            upd_pend_d           = 1'b1;
            upd_cmd_d.prefix     = upd_prefix_i;
            upd_cmd_d.prefix_len = sat_prefix_len(upd_prefix_len_i);
            upd_cmd_d.stage_id   = upd_stage_id_i;
            upd_cmd_d.location   = upd_location_i;
            upd_cmd_d.result     = upd_result_i;
        end
    end

    // Output slot, burst counter and pending update registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_q      <= '0;
            burst_cnt_q <= '0;
            upd_pend_q  <= 1'b0;
            upd_cmd_q   <= '0;
        end else begin
            slot_q      <= slot_d;
            burst_cnt_q <= burst_cnt_d;
            upd_pend_q  <= upd_pend_d;
            upd_cmd_q   <= upd_cmd_d;
        end
    end

    assign update_o   = slot_q.update;
    assign ip_addr_o  = slot_q.ip_addr;
    assign bit_pos_o  = slot_q.bit_pos;
    assign stage_id_o = slot_q.stage_id;
    assign location_o = slot_q.location;
    assign result_o   = slot_q.result;

`ifdef SBP_INGRESS_STATS_EN
    logic [31:0] cnt_lookup_q, cnt_lookup_d;
    logic [31:0] cnt_update_q, cnt_update_d;

    // Saturating counts of emitted lookup and update slots.
    always_comb begin
        cnt_lookup_d = cnt_lookup_q;
        cnt_update_d = cnt_update_q;
        if (sel_lk && (cnt_lookup_q != '1)) begin
            cnt_lookup_d = cnt_lookup_q + 32'd1;
        end
        if (sel_upd && (cnt_update_q != '1)) begin
            cnt_update_d = cnt_update_q + 32'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_lookup_q <= '0;
            cnt_update_q <= '0;
        end else begin
            cnt_lookup_q <= cnt_lookup_d;
            cnt_update_q <= cnt_update_d;
        end
    end

    assign cnt_lookup_o = cnt_lookup_q;
    assign cnt_update_o = cnt_update_q;
`endif

endmodule

// File: tb/tb_sbp_lookup_ingress.sv
// Self-checking bench for sbp_lookup_ingress: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_sbp_lookup_ingress;
    import sbp_pkg::*;

    localparam int FIRST_STAGE_ID = 1;
    localparam int FIFO_DEPTH     = 4;
    localparam int MAX_UPD_BURST  = 8;

    logic                     clk;
    logic                     rst;
    logic                     lk_valid_i;
    logic                     lk_ready_o;
    logic [31:0]              lk_ip_addr_i;
    logic                     upd_valid_i;
    logic                     upd_ready_o;
    logic [31:0]              upd_prefix_i;
    logic [5:0]               upd_prefix_len_i;
    logic [STAGE_ID_BITS-1:0] upd_stage_id_i;
    logic [LOCATION_BITS-1:0] upd_location_i;
    logic [RESULT_BITS-1:0]   upd_result_i;
    logic                     update_o;
    logic [31:0]              ip_addr_o;
    logic [5:0]               bit_pos_o;
    logic [STAGE_ID_BITS-1:0] stage_id_o;
    logic [LOCATION_BITS-1:0] location_o;
    logic [RESULT_BITS-1:0]   result_o;
`ifdef SBP_INGRESS_STATS_EN
    logic [31:0]              cnt_lookup_o;
    logic [31:0]              cnt_update_o;
`endif

    sbp_lookup_ingress #(
        .FIRST_STAGE_ID (FIRST_STAGE_ID),
        .FIFO_DEPTH     (FIFO_DEPTH),
        .MAX_UPD_BURST  (MAX_UPD_BURST)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .lk_valid_i       (lk_valid_i),
        .lk_ready_o       (lk_ready_o),
        .lk_ip_addr_i     (lk_ip_addr_i),
        .upd_valid_i      (upd_valid_i),
        .upd_ready_o      (upd_ready_o),
        .upd_prefix_i     (upd_prefix_i),
        .upd_prefix_len_i (upd_prefix_len_i),
        .upd_stage_id_i   (upd_stage_id_i),
        .upd_location_i   (upd_location_i),
        .upd_result_i     (upd_result_i),
        .update_o         (update_o),
        .ip_addr_o        (ip_addr_o),
        .bit_pos_o        (bit_pos_o),
        .stage_id_o       (stage_id_o),
        .location_o       (location_o),
`ifdef SBP_INGRESS_STATS_EN
        .cnt_lookup_o     (cnt_lookup_o),
        .cnt_update_o     (cnt_update_o),
`endif
        .result_o         (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: lookups are a queue tagged with the edge that accepted
    // them; a lookup may only be chosen from the cycle after the next edge.
    typedef struct {
        logic [31:0] addr;
        int          edge_no;
    } lk_ent_t;

    lk_ent_t   lk_q[$];
    bit        m_pend;
    sbp_slot_t m_pend_slot;
    int        m_burst;
    int        cur_edge;

    sbp_slot_t obs_slot;
    bit        last_lk_ready;
    bit        last_upd_ready;
    bit        lk_acc;

    task automatic model_reset();
        lk_q.delete();
        m_pend  = 1'b0;
        m_pend_slot = '0;
        m_burst = 0;
    endtask

    // One clock: drive inputs after the falling edge, check readys, predict the
    // slot, advance the model, then check the registered slot after the rising edge.
    task automatic step(input bit lv, input logic [31:0] la, input bit uv,
                        input logic [31:0] pfx, input logic [5:0] len,
                        input logic [5:0] st, input logic [10:0] loc,
                        input logic [23:0] res);
        bit        vis;
        bit        s_upd;
        bit        s_lk;
        bit        e_lr;
        bit        e_ur;
        sbp_slot_t e;
        lk_valid_i       = lv;
        lk_ip_addr_i     = la;
        upd_valid_i      = uv;
        upd_prefix_i     = pfx;
        upd_prefix_len_i = len;
        upd_stage_id_i   = st;
        upd_location_i   = loc;
        upd_result_i     = res;
        #1;
        vis   = (lk_q.size() > 0) && (lk_q[0].edge_no < cur_edge);
        s_upd = m_pend && ((m_burst < MAX_UPD_BURST) || !vis);
        s_lk  = !s_upd && vis;
        e_lr  = (lk_q.size() < FIFO_DEPTH) || s_lk;
        e_ur  = !m_pend || s_upd;
        last_lk_ready  = lk_ready_o;
        last_upd_ready = upd_ready_o;
        check($sformatf("lk_ready@%0d", cur_edge), 128'(lk_ready_o), 128'(e_lr));
        check($sformatf("upd_ready@%0d", cur_edge), 128'(upd_ready_o), 128'(e_ur));

        e = '0;
        if (s_upd) begin
            e = m_pend_slot;
        end else if (s_lk) begin
            e.ip_addr  = lk_q[0].addr;
            e.stage_id = 6'(FIRST_STAGE_ID);
        end

        if (s_lk) void'(lk_q.pop_front());
        if (s_upd) begin
            m_pend  = 1'b0;
            m_burst = (m_burst < MAX_UPD_BURST) ? m_burst + 1 : MAX_UPD_BURST;
        end else begin
            m_burst = 0;
        end
        lk_acc = lv && e_lr;
        if (lk_acc) lk_q.push_back('{la, cur_edge + 1});
        if (uv && e_ur && (st != 6'd0)) begin
            m_pend               = 1'b1;
            m_pend_slot.update   = 1'b1;
            m_pend_slot.ip_addr  = pfx;
            m_pend_slot.bit_pos  = (len > 6'd32) ? 6'd32 : len;
            m_pend_slot.stage_id = st;
            m_pend_slot.location = loc;
            m_pend_slot.result   = res;
        end

        @(posedge clk);
        cur_edge++;
        #1;
        obs_slot.update   = update_o;
        obs_slot.ip_addr  = ip_addr_o;
        obs_slot.bit_pos  = bit_pos_o;
        obs_slot.stage_id = stage_id_o;
        obs_slot.location = location_o;
        obs_slot.result   = result_o;
        check($sformatf("slot@%0d", cur_edge), 128'(obs_slot), 128'(e));
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 32'h0, 6'd0, 6'd0, 11'd0, 24'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lk_sent;
        int upd_run;
        int lk_seen;

        rst = 1'b0;
        lk_valid_i = 1'b0;  lk_ip_addr_i = '0;
        upd_valid_i = 1'b0; upd_prefix_i = '0; upd_prefix_len_i = '0;
        upd_stage_id_i = '0; upd_location_i = '0; upd_result_i = '0;
        cur_edge = 0;
        model_reset();

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset_update", 128'(update_o), 128'(0));
        check("reset_ip", 128'(ip_addr_o), 128'(0));
        check("reset_stage", 128'(stage_id_o), 128'(0));
        rst = 1'b1;
        #1;
        check("reset_lk_ready", 128'(lk_ready_o), 128'(1));
        check("reset_upd_ready", 128'(upd_ready_o), 128'(1));
        @(negedge clk);

        // 1: single lookup appears after the second edge, bubbles around it.
        step(1'b1, 32'hC0A80101, 1'b0, 32'h0, 6'd0, 6'd0, 11'd0, 24'd0);
        check("t1_edgeN_bubble", 128'(stage_id_o), 128'(0));
        idle();
        check("t1_edgeN1_bubble", 128'(stage_id_o), 128'(0));
        idle();
        check("t1_ip", 128'(ip_addr_o), 128'(32'hC0A80101));
        check("t1_stage", 128'(stage_id_o), 128'(1));
        check("t1_update", 128'(update_o), 128'(0));
        idle();
        check("t1_after_bubble", 128'(stage_id_o), 128'(0));

        // 2: one update slot, one edge after acceptance.
        step(1'b0, 32'h0, 1'b1, 32'h0A000000, 6'd8, 6'd3, 11'd5, 24'h031050);
        idle();
        check("t2_update", 128'(update_o), 128'(1));
        check("t2_bit_pos", 128'(bit_pos_o), 128'(8));
        check("t2_stage", 128'(stage_id_o), 128'(3));
        check("t2_location", 128'(location_o), 128'(5));
        idle();

        // 3: continuous updates with 6 lookups -> 8 updates then 1 lookup.
        lk_sent = 0; upd_run = 0; lk_seen = 0;
        for (int i = 0; i < 70; i++) begin
            step(lk_sent < 6, 32'h1000 + 32'(lk_sent), 1'b1, $urandom,
                 6'($urandom_range(0, 32)), 6'($urandom_range(1, 63)),
                 11'($urandom), 24'($urandom));
            if (lk_acc) lk_sent++;
            if (obs_slot.update) begin
                upd_run++;
            end else if (obs_slot.stage_id != 6'd0) begin
                lk_seen++;
                check("t3_burst_len", 128'(upd_run), 128'(MAX_UPD_BURST));
                upd_run = 0;
            end
        end
        check("t3_lookups_out", 128'(lk_seen), 128'(6));
        repeat (3) idle();

        // 4: lookups every cycle, no updates -> ready stays high, in order.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 32'h2000 + 32'(i), 1'b0, 32'h0, 6'd0, 6'd0, 11'd0, 24'd0);
            check("t4_ready_high", 128'(last_lk_ready), 128'(1));
        end
        repeat (4) idle();

        // 5: length saturation and discarded stage-0 update.
        step(1'b0, 32'h0, 1'b1, 32'h0B000000, 6'd40, 6'd7, 11'd9, 24'h123456);
        idle();
        check("t5_len_sat", 128'(bit_pos_o), 128'(32));
        step(1'b0, 32'h0, 1'b1, 32'h0C000000, 6'd16, 6'd0, 11'd3, 24'h000111);
        check("t5_stage0_ready", 128'(last_upd_ready), 128'(1));
        for (int i = 0; i < 3; i++) begin
            idle();
            check("t5_no_update", 128'(update_o), 128'(0));
        end

        // 6: reset with 3 lookups queued and an update pending.
        for (int i = 0; i < 4; i++) begin
            step(i < 3, 32'h3000 + 32'(i), 1'b1, 32'h0D000000, 6'd12,
                 6'd2, 11'(i), 24'h000222);
        end
        lk_valid_i = 1'b0; upd_valid_i = 1'b0;
        rst = 1'b0;
        #1;
        model_reset();
        check("t6_rst_update", 128'(update_o), 128'(0));
        check("t6_rst_stage", 128'(stage_id_o), 128'(0));
        @(posedge clk);
        cur_edge++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_lk_ready", 128'(lk_ready_o), 128'(1));
        check("t6_upd_ready", 128'(upd_ready_o), 128'(1));
        for (int i = 0; i < 4; i++) begin
            idle();
            check("t6_no_stale", 128'(stage_id_o), 128'(0));
        end

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 60, $urandom,
                 $urandom_range(0, 99) < 40, $urandom,
                 6'($urandom_range(0, 63)),
                 ($urandom_range(0, 9) == 0) ? 6'd0 : 6'($urandom_range(1, 63)),
                 11'($urandom), 24'($urandom));
        end
        repeat (12) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
